pong_ball_engine: RTL

Parametrised successor to the fixed-field ball mover. It steps a one-cell ball across a configurable playfield and bounces it off the side walls and two horizontal paddles: bar1 at the top, bar2 at the bottom. It keeps saturating scores and runs a serve/play/game-over state machine. Ball motion is gated by a `tick` strobe, so ball speed is set externally. The block sits between the paddle controllers and the video renderer/score display.

---
 rtl/pong_pkg.sv | 18 +
 rtl/pong_paddle_hit.sv | 50 +++++
 rtl/pong_ball_engine.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball engine: game state encoding,
// default widths and the direction-bit meanings used on up/der.
package pong_pkg;

    localparam int COORD_W_DEF = 7;
    localparam int SCORE_W_DEF = 4;

    // Direction bits: up=1 moves toward row 0, der=1 moves toward X_MAX.
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_e;

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational paddle collision test for one horizontal paddle.
// Ports:
//   ball_x_i, ball_y_i : current ball position
//   pad_x_i,  pad_y_i  : paddle left column and row
//   up_i               : ball vertical direction (1 = toward row 0)
//   hit_o              : ball is adjacent to the paddle, inside its span,
//                        and moving toward it
//   left_half_o        : ball sits in the left half of the paddle
// IS_TOP selects the top paddle (ball below it, moving up) or the bottom
// paddle (ball above it, moving down).
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int PAD_W   = 6,
    parameter bit IS_TOP  = 1'b1
) (
    input  logic [COORD_W-1:0] ball_x_i,
    input  logic [COORD_W-1:0] ball_y_i,
    input  logic [COORD_W-1:0] pad_x_i,
    input  logic [COORD_W-1:0] pad_y_i,
    input  logic               up_i,
    output logic               hit_o,
    output logic               left_half_o
);

    // One extra bit so a paddle near X_MAX (or a row near the limit)
    // never wraps around and matches coordinates near 0.
    localparam int W = COORD_W + 1;
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] PAD_LAST = W'(PAD_W - 1);
    localparam logic [W-1:0] HALF     = W'(PAD_W / 2);

    logic [W-1:0] bx, by, px, py, off;
    logic         row_ok, span_ok, dir_ok;

    assign bx  = {1'b0, ball_x_i};
    assign by  = {1'b0, ball_y_i};
    assign px  = {1'b0, pad_x_i};
    assign py  = {1'b0, pad_y_i};
    assign off = bx - px;

    assign row_ok  = IS_TOP ? (by == py + ONE) : (by + ONE == py);
    assign dir_ok  = IS_TOP ? (up_i == DIR_UP) : (up_i != DIR_UP);
    assign span_ok = (bx >= px) && (bx <= px + PAD_LAST);

    assign hit_o       = row_ok && span_ok && dir_ok;
    assign left_half_o = off < HALF;

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: steps a one-cell ball on tick strobes, bounces it off
// the side walls and two horizontal paddles, keeps saturating scores and
// sequences serve / play / game-over.
// Ports:
//   clk, reset            : clock, async active-high reset
//   tick                  : one-clk movement strobe
//   x_bar1, y_bar1        : top paddle left column / row
//   x_bar2, y_bar2        : bottom paddle left column / row
//   x_place, y_place      : ball position
//   up, der               : ball direction (toward row 0 / toward X_MAX)
//   point1, point2        : player scores
//   scored1, scored2      : one-clk score pulses
//   game_over, serving    : state flags
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int X_MAX       = 127,
    parameter int Y_MAX       = 95,
    parameter int X_START     = 63,
    parameter int Y_START     = 47,
    parameter int PAD_W       = 6,
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int SCORE_WIN   = 9,
    parameter int SERVE_TICKS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [COORD_W-1:0] x_bar1,
    input  logic [COORD_W-1:0] y_bar1,
    input  logic [COORD_W-1:0] x_bar2,
    input  logic [COORD_W-1:0] y_bar2,
    output logic [COORD_W-1:0] x_place,
    output logic [COORD_W-1:0] y_place,
    output logic               up,
    output logic               der,
    output logic [SCORE_W-1:0] point1,
    output logic [SCORE_W-1:0] point2,
    output logic               scored1,
    output logic               scored2,
    output logic               game_over,
    output logic               serving
);

    localparam int CNT_W = $clog2(SERVE_TICKS + 1);
    localparam logic [COORD_W-1:0] XS     = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] YS     = COORD_W'(Y_START);
    localparam logic [COORD_W-1:0] XM     = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM     = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
    localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(SCORE_WIN);
    localparam logic [SCORE_W-1:0] S_ONE  = SCORE_W'(1);
    localparam logic [CNT_W-1:0]   RELOAD = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   N_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               up_q, up_d, der_q, der_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic               s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic hit1, left1, hit2, left2;
    logic up_nx, der_nx;

    pong_paddle_hit #(.COORD_W(COORD_W), .PAD_W(PAD_W), .IS_TOP(1'b1)) u_hit_bar1 (
        .ball_x_i   (x_q),
        .ball_y_i   (y_q),
        .pad_x_i    (x_bar1),
        .pad_y_i    (y_bar1),
        .up_i       (up_q),
        .hit_o      (hit1),
        .left_half_o(left1)
    );

    pong_paddle_hit #(.COORD_W(COORD_W), .PAD_W(PAD_W), .IS_TOP(1'b0)) u_hit_bar2 (
        .ball_x_i   (x_q),
        .ball_y_i   (y_q),
        .pad_x_i    (x_bar2),
        .pad_y_i    (y_bar2),
        .up_i       (up_q),
        .hit_o      (hit2),
        .left_half_o(left2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SERVE;
            x_q     <= XS;
            y_q     <= YS;
            up_q    <= ~DIR_UP;
            der_q   <= DIR_RIGHT;
            p1_q    <= '0;
            p2_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= RELOAD;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            up_q    <= up_d;
            der_q   <= der_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        up_d    = up_q;
        der_d   = der_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        s1_d    = 1'b0;
        s2_d    = 1'b0;
        cnt_d   = cnt_q;
        up_nx   = up_q;
        der_nx  = der_q;

        case (state_q)
            SERVE: begin
                if (tick) begin
                    if (cnt_q == '0) state_d = PLAY;
                    else             cnt_d   = cnt_q - N_ONE;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (hit1) begin
                        up_nx  = ~DIR_UP;
                        der_nx = left1 ? ~DIR_RIGHT : DIR_RIGHT;
                    end else if (hit2) begin
                        up_nx  = DIR_UP;
                        der_nx = left2 ? ~DIR_RIGHT : DIR_RIGHT;
                    end

                    if (!hit1 && !hit2 && y_q == YM) begin
                        p1_d    = (p1_q == WIN) ? p1_q : p1_q + S_ONE;
                        s1_d    = 1'b1;
                        x_d     = XS;
                        y_d     = YS;
                        up_d    = ~DIR_UP;
                        der_d   = ~DIR_RIGHT;
                        cnt_d   = RELOAD;
                        state_d = (p1_d == WIN) ? OVER : SERVE;
                    end else if (!hit1 && !hit2 && y_q == '0) begin
                        p2_d    = (p2_q == WIN) ? p2_q : p2_q + S_ONE;
                        s2_d    = 1'b1;
                        x_d     = XS;
                        y_d     = YS;
                        up_d    = DIR_UP;
                        der_d   = DIR_RIGHT;
                        cnt_d   = RELOAD;
                        state_d = (p2_d == WIN) ? OVER : SERVE;
                    end else begin
                        // Walls take precedence over the paddle half choice.
                        if (x_q == '0) der_nx = DIR_RIGHT;
                        if (x_q == XM) der_nx = ~DIR_RIGHT;
                        up_d  = up_nx;
                        der_d = der_nx;
                        x_d   = (der_nx == DIR_RIGHT) ? x_q + C_ONE : x_q - C_ONE;
                        y_d   = (up_nx == DIR_UP)     ? y_q - C_ONE : y_q + C_ONE;
                    end
                end
            end
            OVER: begin
            end
            default: state_d = SERVE;
        endcase
    end

    assign x_place   = x_q;
    assign y_place   = y_q;
    assign up        = up_q;
    assign der       = der_q;
    assign point1    = p1_q;
    assign point2    = p2_q;
    assign scored1   = s1_q;
    assign scored2   = s2_q;
    assign game_over = (state_q == OVER);
    assign serving   = (state_q == SERVE);

endmodule
